// File: rtl/dma_burst_loader.sv
// Host command decoder that writes data bytes into one of NUM_CH on-chip banks,
// with single writes, length-prefixed auto-incrementing bursts, abort and start pulses.
module dma_burst_loader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NUM_CH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        cmd_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              wr_en,
    output logic [NUM_CH-1:0] wr_ch,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [1:0] {StIdle, StLen, StBurst} state_e;

    localparam logic [2:0]        OpNop   = 3'b000;
    localparam logic [2:0]        OpStart = 3'b100;
    localparam logic [2:0]        OpClear = 3'b110;
    localparam logic [2:0]        OpAbort = 3'b111;
    localparam logic [ADDR_W:0]   DepthLen = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   ch_q, ch_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;

    logic                wr_en_d, start_d, busy_d, done_d, overflow_d;
    logic [NUM_CH-1:0]   wr_ch_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [DATA_W-1:0]   wr_data_d;

    logic [2:0]          op;
    logic [NUM_CH-1:0]   op_onehot;
    logic [ADDR_W:0]     len_raw, len_eff;

    always_comb begin
        op = cmd_in[7:5];
        for (int i = 0; i < int'(NUM_CH); i++) begin
            op_onehot[i] = (int'(op) == i + 1);
        end
        len_raw = data_in[ADDR_W:0];
        // Zero or oversize lengths mean a full-bank burst.
        len_eff = (len_raw == '0 || len_raw > DepthLen) ? DepthLen : len_raw;
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wr_en_d    = 1'b0;
        wr_ch_d    = '0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        start_d    = 1'b0;
        done_d     = 1'b0;
        overflow_d = overflow_q_w();

        unique case (state_q)
            StIdle: begin
                case (op)
                    OpNop, OpAbort: ;
                    OpStart: start_d = 1'b1;
                    OpClear: overflow_d = 1'b0;
                    default: begin
                        if (|op_onehot) begin
                            if (cmd_in[4]) begin
                                ch_d    = op_onehot;
                                addr_d  = cmd_in[ADDR_W-1:0];
                                state_d = StLen;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_ch_d   = op_onehot;
                                wr_addr_d = cmd_in[ADDR_W-1:0];
                                wr_data_d = data_in;
                            end
                        end
                    end
                endcase
            end
            StLen: begin
                if (op == OpAbort) begin
                    state_d = StIdle;
                end else if (data_valid) begin
                    cnt_d   = len_eff;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (op == OpAbort) begin
                    state_d = StIdle;
                end else if (data_valid) begin
                    wr_en_d   = 1'b1;
                    wr_ch_d   = ch_q;
                    wr_addr_d = addr_q;
                    wr_data_d = data_in;
                    if (addr_q == LastAddr) begin
                        addr_d     = '0;
                        overflow_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == (ADDR_W + 1)'(1)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    function automatic logic overflow_q_w();
        return overflow;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            wr_en    <= 1'b0;
            wr_ch    <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            start    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            wr_en    <= wr_en_d;
            wr_ch    <= wr_ch_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            start    <= start_d;
            busy     <= busy_d;
            done     <= done_d;
            overflow <= overflow_d;
        end
    end

endmodule

// File: tb/tb_dma_burst_loader.sv
// Directed self-checking bench for dma_burst_loader: single writes, bursts with bubbles,
// address wrap and overflow clear, abort, start pulses and asynchronous reset.
module tb_dma_burst_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cmd_in;
    logic [7:0] data_in;
    logic       data_valid;
    logic       wr_en;
    logic [2:0] wr_ch;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    dma_burst_loader #(
        .DATA_W(8),
        .ADDR_W(4),
        .DEPTH (16),
        .NUM_CH(3)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_in    (cmd_in),
        .data_in   (data_in),
        .data_valid(data_valid),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] c, input logic [7:0] d, input logic v);
        cmd_in     = c;
        data_in    = d;
        data_valid = v;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [2:0] ch,
                            input logic [3:0] addr, input logic [7:0] data);
        check({tag, ".wr_en"}, 32'(wr_en), 32'(en));
        check({tag, ".wr_ch"}, 32'(wr_ch), 32'(ch));
        if (en) begin
            check({tag, ".wr_addr"}, 32'(wr_addr), 32'(addr));
            check({tag, ".wr_data"}, 32'(wr_data), 32'(data));
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(8'h00, 8'h00, 1'b0);
        step();
        step();
        check_wr("rst", 1'b0, 3'b000, 4'h0, 8'h00);
        check("rst.wr_addr", 32'(wr_addr), 32'h0);
        check("rst.start", 32'(start), 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.done", 32'(done), 32'h0);
        check("rst.ovf", 32'(overflow), 32'h0);
        reset = 1'b1;

        // Single write, data_valid ignored
        drive(8'h25, 8'hA7, 1'b0);
        step();
        check_wr("single", 1'b1, 3'b001, 4'h5, 8'hA7);
        check("single.busy", 32'(busy), 32'h0);
        drive(8'h00, 8'h00, 1'b0);
        step();
        check_wr("single.after", 1'b0, 3'b000, 4'h0, 8'h00);

        // Undefined opcode 101 is a NOP
        drive(8'hA3, 8'h55, 1'b1);
        step();
        check_wr("nop101", 1'b0, 3'b000, 4'h0, 8'h00);
        check("nop101.busy", 32'(busy), 32'h0);

        // Burst ch1 base 2, length 3, one bubble
        drive(8'h52, 8'h00, 1'b0);
        step();
        check("burst.busy_len", 32'(busy), 32'h1);
        check_wr("burst.len", 1'b0, 3'b000, 4'h0, 8'h00);
        drive(8'h00, 8'h00, 1'b0);
        step();
        check("burst.len_hold", 32'(busy), 32'h1);
        drive(8'h00, 8'h03, 1'b1);
        step();
        check_wr("burst.lenbyte", 1'b0, 3'b000, 4'h0, 8'h00);
        drive(8'h00, 8'h11, 1'b1);
        step();
        check_wr("burst.w0", 1'b1, 3'b010, 4'h2, 8'h11);
        check("burst.w0.done", 32'(done), 32'h0);
        drive(8'h00, 8'hEE, 1'b0);
        step();
        check_wr("burst.bubble", 1'b0, 3'b000, 4'h0, 8'h00);
        check("burst.bubble.busy", 32'(busy), 32'h1);
        drive(8'h00, 8'h22, 1'b1);
        step();
        check_wr("burst.w1", 1'b1, 3'b010, 4'h3, 8'h22);
        drive(8'h00, 8'h33, 1'b1);
        step();
        check_wr("burst.w2", 1'b1, 3'b010, 4'h4, 8'h33);
        check("burst.w2.done", 32'(done), 32'h1);
        check("burst.w2.busy", 32'(busy), 32'h0);
        drive(8'h00, 8'h00, 1'b0);
        step();
        check("burst.after.done", 32'(done), 32'h0);
        check_wr("burst.after", 1'b0, 3'b000, 4'h0, 8'h00);

        // Wrap: ch2 base 14 length 4
        drive(8'h7E, 8'h00, 1'b0);
        step();
        drive(8'h00, 8'h04, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] ea;
            ea = 4'(14 + i);
            drive(8'h00, 8'(8'hA0 + i), 1'b1);
            step();
            check_wr($sformatf("wrap.w%0d", i), 1'b1, 3'b100, ea, 8'(8'hA0 + i));
            check($sformatf("wrap.ovf%0d", i), 32'(overflow), (i >= 1) ? 32'h1 : 32'h0);
            check($sformatf("wrap.done%0d", i), 32'(done), (i == 3) ? 32'h1 : 32'h0);
        end
        drive(8'h00, 8'h00, 1'b0);
        step();
        check("wrap.ovf_sticky", 32'(overflow), 32'h1);
        drive(8'hC0, 8'h00, 1'b0);
        step();
        check("wrap.ovf_clear", 32'(overflow), 32'h0);

        // Abort: ch0 burst length 8, 3 words then abort with valid data
        drive(8'h30, 8'h00, 1'b0);
        step();
        drive(8'h00, 8'h08, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(8'h00, 8'(8'h40 + i), 1'b1);
            step();
            check_wr($sformatf("abort.w%0d", i), 1'b1, 3'b001, 4'(i), 8'(8'h40 + i));
        end
        drive(8'hE0, 8'hFF, 1'b1);
        step();
        check_wr("abort.cyc", 1'b0, 3'b000, 4'h0, 8'h00);
        check("abort.done", 32'(done), 32'h0);
        check("abort.busy", 32'(busy), 32'h0);
        drive(8'h00, 8'h00, 1'b0);
        step();
        check("abort.idle_busy", 32'(busy), 32'h0);

        // Start in IDLE, held for two cycles
        drive(8'h80, 8'h00, 1'b0);
        step();
        check("start.p0", 32'(start), 32'h1);
        drive(8'h00, 8'h00, 1'b0);
        step();
        check("start.off", 32'(start), 32'h0);
        drive(8'h80, 8'h00, 1'b0);
        step();
        check("start.h0", 32'(start), 32'h1);
        step();
        check("start.h1", 32'(start), 32'h1);
        drive(8'h00, 8'h00, 1'b0);
        step();
        check("start.h_off", 32'(start), 32'h0);

        // Start ignored during BURST
        drive(8'h30, 8'h00, 1'b0);
        step();
        drive(8'h00, 8'h02, 1'b1);
        step();
        drive(8'h80, 8'h00, 1'b0);
        step();
        check("start.burst0", 32'(start), 32'h0);
        step();
        check("start.burst1", 32'(start), 32'h0);
        check("start.burst_busy", 32'(busy), 32'h1);
        drive(8'h00, 8'h61, 1'b1);
        step();
        check_wr("start.bw0", 1'b1, 3'b001, 4'h0, 8'h61);
        drive(8'h00, 8'h62, 1'b1);
        step();
        check_wr("start.bw1", 1'b1, 3'b001, 4'h1, 8'h62);
        check("start.bdone", 32'(done), 32'h1);

        // Asynchronous reset mid-burst
        drive(8'h30, 8'h00, 1'b0);
        step();
        drive(8'h00, 8'h05, 1'b1);
        step();
        drive(8'h00, 8'h77, 1'b1);
        step();
        check_wr("rstmid.w0", 1'b1, 3'b001, 4'h0, 8'h77);
        #2;
        reset = 1'b0;
        #1;
        check_wr("rstmid.async", 1'b0, 3'b000, 4'h0, 8'h00);
        check("rstmid.wr_data", 32'(wr_data), 32'h0);
        check("rstmid.busy", 32'(busy), 32'h0);
        drive(8'h00, 8'h00, 1'b0);
        step();
        reset = 1'b1;
        drive(8'h20, 8'h5A, 1'b0);
        step();
        check_wr("rstmid.single", 1'b1, 3'b001, 4'h0, 8'h5A);
        check("rstmid.single_busy", 32'(busy), 32'h0);
        drive(8'h00, 8'h00, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
